// File: rtl/dram_arbiter.sv
// rtl/dram_arbiter.sv - round-robin arbiter sharing one DRAM channel between I$ refill and D$ miss/store paths.
// One transaction outstanding at a time; I$ responses are dropped after a front-end flush.
module dram_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int BLOCK_SIZE = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ic_req_valid,
  input  logic [ADDR_WIDTH-1:0] ic_req_addr,
  output logic                  ic_req_ready,
  input  logic                  ic_flush,
  output logic                  ic_resp_valid,
  output logic [BLOCK_SIZE-1:0] ic_resp_data,
  input  logic                  dc_req_valid,
  input  logic [ADDR_WIDTH-1:0] dc_req_addr,
  input  logic                  dc_req_is_st,
  input  logic [BLOCK_SIZE-1:0] dc_req_wdata,
  output logic                  dc_req_ready,
  output logic                  dc_resp_valid,
  output logic [BLOCK_SIZE-1:0] dc_resp_data,
  output logic                  dram_req_valid,
  input  logic                  dram_req_ready,
  output logic [ADDR_WIDTH-1:0] dram_req_addr,
  output logic                  dram_req_is_st,
  output logic [BLOCK_SIZE-1:0] dram_req_wdata,
  input  logic                  dram_resp_valid,
  input  logic [BLOCK_SIZE-1:0] dram_resp_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam logic OWN_IC = 1'b0;
  localparam logic OWN_DC = 1'b1;

  state_t                  state_q, state_d;
  logic                    owner_q, owner_d;
  logic                    last_grant_q, last_grant_d;
  logic                    squash_q, squash_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    is_st_q, is_st_d;
  logic [BLOCK_SIZE-1:0]   wdata_q, wdata_d;
  logic                    ic_resp_valid_q, ic_resp_valid_d;
  logic [BLOCK_SIZE-1:0]   ic_resp_data_q, ic_resp_data_d;
  logic                    dc_resp_valid_q, dc_resp_valid_d;
  logic [BLOCK_SIZE-1:0]   dc_resp_data_q, dc_resp_data_d;

  logic ic_elig, dc_elig, pick_ic, pick_dc;

  // A flushing front end cannot start a refill; on a tie the side not granted last wins.
  assign ic_elig = ic_req_valid & ~ic_flush;
  assign dc_elig = dc_req_valid;
  assign pick_ic = ic_elig & (~dc_elig | (last_grant_q == OWN_DC));
  assign pick_dc = dc_elig & ~pick_ic;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      owner_q         <= OWN_IC;
      last_grant_q    <= OWN_DC;
      squash_q        <= 1'b0;
      addr_q          <= '0;
      is_st_q         <= 1'b0;
      wdata_q         <= '0;
      ic_resp_valid_q <= 1'b0;
      ic_resp_data_q  <= '0;
      dc_resp_valid_q <= 1'b0;
      dc_resp_data_q  <= '0;
    end else begin
      state_q         <= state_d;
      owner_q         <= owner_d;
      last_grant_q    <= last_grant_d;
      squash_q        <= squash_d;
      addr_q          <= addr_d;
      is_st_q         <= is_st_d;
      wdata_q         <= wdata_d;
      ic_resp_valid_q <= ic_resp_valid_d;
      ic_resp_data_q  <= ic_resp_data_d;
      dc_resp_valid_q <= dc_resp_valid_d;
      dc_resp_data_q  <= dc_resp_data_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    owner_d         = owner_q;
    last_grant_d    = last_grant_q;
    squash_d        = squash_q;
    addr_d          = addr_q;
    is_st_d         = is_st_q;
    wdata_d         = wdata_q;
    ic_resp_valid_d = 1'b0;
    ic_resp_data_d  = ic_resp_data_q;
    dc_resp_valid_d = 1'b0;
    dc_resp_data_d  = dc_resp_data_q;
    ic_req_ready    = 1'b0;
    dc_req_ready    = 1'b0;
    dram_req_valid  = 1'b0;

    case (state_q)
      IDLE: begin
        ic_req_ready = pick_ic;
        dc_req_ready = pick_dc;
        if (pick_ic || pick_dc) begin
          addr_d       = pick_ic ? ic_req_addr : dc_req_addr;
          is_st_d      = pick_dc & dc_req_is_st;
          wdata_d      = pick_ic ? '0 : dc_req_wdata;
          owner_d      = pick_dc ? OWN_DC : OWN_IC;
          last_grant_d = pick_dc ? OWN_DC : OWN_IC;
          state_d      = ISSUE;
        end
      end

      ISSUE: begin
        // The DRAM request is never retracted; a flush only marks the reply for dropping.
        dram_req_valid = 1'b1;
        if ((owner_q == OWN_IC) && ic_flush) squash_d = 1'b1;
        if (dram_req_ready) state_d = WAIT;
      end

      WAIT: begin
        if ((owner_q == OWN_IC) && ic_flush) squash_d = 1'b1;
        if (dram_resp_valid) begin
          state_d  = IDLE;
          squash_d = 1'b0;
          if (owner_q == OWN_DC) begin
            dc_resp_valid_d = 1'b1;
            dc_resp_data_d  = is_st_q ? '0 : dram_resp_data;
          end else if (!squash_q && !ic_flush) begin
            ic_resp_valid_d = 1'b1;
            ic_resp_data_d  = dram_resp_data;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign dram_req_addr  = addr_q;
  assign dram_req_is_st = is_st_q;
  assign dram_req_wdata = wdata_q;
  assign ic_resp_valid  = ic_resp_valid_q;
  assign ic_resp_data   = ic_resp_data_q;
  assign dc_resp_valid  = dc_resp_valid_q;
  assign dc_resp_data   = dc_resp_data_q;

endmodule

// File: tb/tb_dram_arbiter.sv
// tb/tb_dram_arbiter.sv - directed self-checking bench for dram_arbiter.
module tb_dram_arbiter;
  localparam int AW = 32;
  localparam int BW = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          ic_req_valid;
  logic [AW-1:0] ic_req_addr;
  logic          ic_req_ready;
  logic          ic_flush;
  logic          ic_resp_valid;
  logic [BW-1:0] ic_resp_data;
  logic          dc_req_valid;
  logic [AW-1:0] dc_req_addr;
  logic          dc_req_is_st;
  logic [BW-1:0] dc_req_wdata;
  logic          dc_req_ready;
  logic          dc_resp_valid;
  logic [BW-1:0] dc_resp_data;
  logic          dram_req_valid;
  logic          dram_req_ready;
  logic [AW-1:0] dram_req_addr;
  logic          dram_req_is_st;
  logic [BW-1:0] dram_req_wdata;
  logic          dram_resp_valid;
  logic [BW-1:0] dram_resp_data;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dram_arbiter #(.ADDR_WIDTH(AW), .BLOCK_SIZE(BW)) dut (
    .clk(clk), .rst(rst),
    .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr), .ic_req_ready(ic_req_ready),
    .ic_flush(ic_flush), .ic_resp_valid(ic_resp_valid), .ic_resp_data(ic_resp_data),
    .dc_req_valid(dc_req_valid), .dc_req_addr(dc_req_addr), .dc_req_is_st(dc_req_is_st),
    .dc_req_wdata(dc_req_wdata), .dc_req_ready(dc_req_ready),
    .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data),
    .dram_req_valid(dram_req_valid), .dram_req_ready(dram_req_ready),
    .dram_req_addr(dram_req_addr), .dram_req_is_st(dram_req_is_st),
    .dram_req_wdata(dram_req_wdata), .dram_resp_valid(dram_resp_valid),
    .dram_resp_data(dram_resp_data)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Entered in the ISSUE cycle; DRAM accepts immediately, one WAIT cycle, then the response.
  // Returns in the cycle after the response with inputs quiet.
  task automatic tail(input logic [63:0] data, input logic fl_wait, input logic fl_resp);
    dram_req_ready = 1'b1;
    step();
    dram_req_ready = 1'b0;
    ic_flush = fl_wait;
    step();
    ic_flush = fl_resp;
    dram_resp_valid = 1'b1;
    dram_resp_data = data;
    step();
    ic_flush = 1'b0;
    dram_resp_valid = 1'b0;
    settle();
  endtask

  initial begin
    rst = 1'b1;
    ic_req_valid = 0; ic_req_addr = '0; ic_flush = 0;
    dc_req_valid = 0; dc_req_addr = '0; dc_req_is_st = 0; dc_req_wdata = '0;
    dram_req_ready = 0; dram_resp_valid = 0; dram_resp_data = '0;

    // reset state
    step(); step(); settle();
    chk("rst_dram_valid", dram_req_valid, 0);
    chk("rst_dram_addr", dram_req_addr, 0);
    chk("rst_dram_is_st", dram_req_is_st, 0);
    chk("rst_dram_wdata", dram_req_wdata, 0);
    chk("rst_ic_resp_valid", ic_resp_valid, 0);
    chk("rst_ic_resp_data", ic_resp_data, 0);
    chk("rst_dc_resp_valid", dc_resp_valid, 0);
    chk("rst_dc_resp_data", dc_resp_data, 0);
    chk("rst_ic_ready", ic_req_ready, 0);
    chk("rst_dc_ready", dc_req_ready, 0);
    rst = 1'b0;

    // 1: single I$ refill
    step();
    step(); ic_req_valid = 1; ic_req_addr = 32'h0000_1040; settle();
    chk("t1_ic_ready", ic_req_ready, 1);
    chk("t1_dc_ready", dc_req_ready, 0);
    step(); ic_req_valid = 0; settle();
    chk("t1_dram_valid_c3", dram_req_valid, 1);
    chk("t1_dram_addr", dram_req_addr, 32'h0000_1040);
    chk("t1_dram_is_st", dram_req_is_st, 0);
    chk("t1_ic_ready_busy", ic_req_ready, 0);
    step(); dram_req_ready = 1; settle();
    chk("t1_dram_valid_c4", dram_req_valid, 1);
    step(); dram_req_ready = 0; settle();
    chk("t1_dram_valid_c5", dram_req_valid, 0);
    step(); step();
    step(); dram_resp_valid = 1; dram_resp_data = 64'hDEAD_BEEF_0000_0013; settle();
    chk("t1_ic_resp_c8", ic_resp_valid, 0);
    step(); dram_resp_valid = 0; settle();
    chk("t1_ic_resp_c9", ic_resp_valid, 1);
    chk("t1_ic_resp_data", ic_resp_data, 64'hDEAD_BEEF_0000_0013);
    chk("t1_dram_valid_c9", dram_req_valid, 0);
    step(); settle();
    chk("t1_ic_resp_c10", ic_resp_valid, 0);

    // 2: round-robin from reset, both always requesting
    rst = 1; step(); rst = 0;
    ic_req_valid = 1; ic_req_addr = 32'h3000;
    dc_req_valid = 1; dc_req_addr = 32'h4000; dc_req_is_st = 0; dc_req_wdata = '0;
    settle();
    for (int i = 0; i < 4; i++) begin
      logic exp_ic;
      exp_ic = (i % 2) == 0;
      chk("rr_ic_ready", ic_req_ready, exp_ic);
      chk("rr_dc_ready", dc_req_ready, !exp_ic);
      if (i > 0) begin
        chk("rr_prev_ic_resp", ic_resp_valid, !exp_ic);
        chk("rr_prev_dc_resp", dc_resp_valid, exp_ic);
        chk("rr_prev_data", exp_ic ? dc_resp_data : ic_resp_data, 64'hA0 + 64'(i - 1));
      end
      step(); dram_req_ready = 1; settle();
      chk("rr_dram_addr", dram_req_addr, exp_ic ? 32'h3000 : 32'h4000);
      chk("rr_ready_busy", {ic_req_ready, dc_req_ready}, 0);
      step(); dram_req_ready = 0;
      step(); dram_resp_valid = 1; dram_resp_data = 64'hA0 + 64'(i);
      step(); dram_resp_valid = 0; settle();
    end
    ic_req_valid = 0; dc_req_valid = 0; settle();
    chk("rr_last_dc_resp", dc_resp_valid, 1);
    chk("rr_last_ic_resp", ic_resp_valid, 0);
    chk("rr_last_data", dc_resp_data, 64'hA3);

    // 3: flush during WAIT drops the refill; next refill is normal
    step(); ic_req_valid = 1; ic_req_addr = 32'h5000; settle();
    chk("t3_ic_ready", ic_req_ready, 1);
    step(); ic_req_valid = 0;
    tail(64'h1111, 1'b1, 1'b0);
    chk("t3_dropped", ic_resp_valid, 0);
    chk("t3_idle", dram_req_valid, 0);
    ic_req_valid = 1; ic_req_addr = 32'h5040; settle();
    chk("t3_reaccept", ic_req_ready, 1);
    step(); ic_req_valid = 0;
    tail(64'h2222, 1'b0, 1'b0);
    chk("t3_resp_valid", ic_resp_valid, 1);
    chk("t3_resp_data", ic_resp_data, 64'h2222);

    // 4: flush coincident with response; flush during dc transaction
    step(); ic_req_valid = 1; ic_req_addr = 32'h6000; settle();
    chk("t4_ic_ready", ic_req_ready, 1);
    step(); ic_req_valid = 0;
    tail(64'h3333, 1'b0, 1'b1);
    chk("t4_coincident_drop", ic_resp_valid, 0);
    dc_req_valid = 1; dc_req_addr = 32'h7000; dc_req_is_st = 0; settle();
    chk("t4_dc_ready", dc_req_ready, 1);
    step(); dc_req_valid = 0; ic_flush = 1; settle();
    chk("t4_dc_issue_held", dram_req_valid, 1);
    tail(64'h4444, 1'b1, 1'b1);
    chk("t4_dc_resp_valid", dc_resp_valid, 1);
    chk("t4_dc_resp_data", dc_resp_data, 64'h4444);
    chk("t4_ic_resp_quiet", ic_resp_valid, 0);

    // 5: store under DRAM backpressure
    step(); dc_req_valid = 1; dc_req_addr = 32'h2000; dc_req_is_st = 1; dc_req_wdata = 64'h55; settle();
    chk("t5_dc_ready", dc_req_ready, 1);
    step(); dc_req_valid = 0; dc_req_addr = '0; dc_req_is_st = 0; dc_req_wdata = 64'hBAD;
    for (int k = 0; k < 5; k++) begin
      settle();
      chk("t5_bp_valid", dram_req_valid, 1);
      chk("t5_bp_addr", dram_req_addr, 32'h2000);
      chk("t5_bp_wdata", dram_req_wdata, 64'h55);
      chk("t5_bp_is_st", dram_req_is_st, 1);
      step();
    end
    dram_req_ready = 1; settle();
    chk("t5_valid_at_ready", dram_req_valid, 1);
    step(); dram_req_ready = 0;
    step(); dram_resp_valid = 1; dram_resp_data = 64'hFFFF;
    step(); dram_resp_valid = 0; settle();
    chk("t5_ack_valid", dc_resp_valid, 1);
    chk("t5_ack_data", dc_resp_data, 0);

    // 6: reset in WAIT, stray response, then ic wins the tie
    step(); ic_req_valid = 1; ic_req_addr = 32'h8000; settle();
    step(); ic_req_valid = 0; dram_req_ready = 1;
    step(); dram_req_ready = 0; settle();
    rst = 1; settle();
    chk("t6_rst_dram_valid", dram_req_valid, 0);
    chk("t6_rst_addr", dram_req_addr, 0);
    chk("t6_rst_ic_data", ic_resp_data, 0);
    chk("t6_rst_dc_valid", dc_resp_valid, 0);
    step(); rst = 0; dram_resp_valid = 1; dram_resp_data = 64'h9999;
    step(); dram_resp_valid = 0; settle();
    chk("t6_stray_ic", ic_resp_valid, 0);
    chk("t6_stray_dc", dc_resp_valid, 0);
    chk("t6_stray_dram", dram_req_valid, 0);
    chk("t6_stray_data", ic_resp_data, 0);
    ic_req_valid = 1; dc_req_valid = 1; settle();
    chk("t6_tie_ic", ic_req_ready, 1);
    chk("t6_tie_dc", dc_req_ready, 0);
    step(); ic_req_valid = 0; dc_req_valid = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dram_arbiter.md
Name: dram_arbiter

Overview:
- Shares the single DRAM request/response channel between the instruction-cache refill path (fed by the fetch unit's I$ miss) and the data-cache miss/store path.
- Grants one requester at a time using round-robin, keeps exactly one DRAM transaction outstanding, and routes the DRAM response back to its owner.
- Drops I$ responses for fetches squashed by a front-end recovery.
- Sits between both caches and the DRAM model; its I$ response outputs drive the I$ fill inputs.

Parameters:
- ADDR_WIDTH, 32, request address width (matches `ADDR_WIDTH).
- BLOCK_SIZE, 64, DRAM transfer width in bits (matches `ICACHE_DATA_BLOCK_SIZE).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- ic_req_valid  in  1  I$ refill request.
- ic_req_addr  in  ADDR_WIDTH  block address of the I$ miss.
- ic_req_ready  out  1  I$ request accepted this cycle (combinational).
- ic_flush  in  1  front-end recovery; squashes any pending or outstanding I$ request.
- ic_resp_valid  out  1  one-cycle pulse; refill data valid (I$ write enable).
- ic_resp_data  out  BLOCK_SIZE  refill block.
- dc_req_valid  in  1  D$ request.
- dc_req_addr  in  ADDR_WIDTH  D$ address.
- dc_req_is_st  in  1  1 = store, 0 = load.
- dc_req_wdata  in  BLOCK_SIZE  store data.
- dc_req_ready  out  1  D$ request accepted this cycle (combinational).
- dc_resp_valid  out  1  one-cycle pulse; load data or store acknowledgement.
- dc_resp_data  out  BLOCK_SIZE  load data; 0 for store acks.
- dram_req_valid  out  1  request to DRAM.
- dram_req_ready  in  1  DRAM accepts the request.
- dram_req_addr  out  ADDR_WIDTH  latched address.
- dram_req_is_st  out  1  latched store flag; 0 for I$ requests.
- dram_req_wdata  out  BLOCK_SIZE  latched store data.
- dram_resp_valid  in  1  DRAM response; exactly one per accepted request, loads and stores alike.
- dram_resp_data  in  BLOCK_SIZE  response data.

Behaviour:
- Reset values:
  - State: IDLE. last_grant = DC, so the I$ wins the first tie. squash = 0.
  - All outputs 0, including latched address/data registers.
  - Reset asserted mid-transaction abandons the transaction. No response is delivered for it.
- States: IDLE, ISSUE, WAIT.
- IDLE:
  - Eligible requesters: ic (ic_req_valid & ~ic_flush) and dc (dc_req_valid).
  - One eligible requester: it wins.
  - Both eligible: the requester not equal to last_grant wins.
  - The winner's ready is 1 combinationally; the loser's ready is 0. Both readies are 0 outside IDLE.
  - On accept: latch addr, is_st (forced 0 for ic) and wdata (ic: 0); set owner and last_grant := owner; go to ISSUE.
- ISSUE:
  - dram_req_valid = 1. Addr, is_st and wdata are stable from the latch registers.
  - Valid is held until dram_req_ready. It is never retracted, even on flush or squash.
  - On dram_req_ready go to WAIT. dram_req_valid = 0 from the next cycle.
- WAIT:
  - On dram_resp_valid, go to IDLE the next cycle.
  - If owner = dc, or owner = ic and squash = 0 and ic_flush = 0: pulse the owner's resp_valid for exactly one cycle (registered, cycle R+1 for response at cycle R), with resp_data = dram_resp_data (dc stores: 0).
  - Otherwise drop the response silently.
- Squash:
  - In ISSUE or WAIT with owner = ic, ic_flush sets squash. squash clears on return to IDLE.
  - ic_flush in the same cycle as dram_resp_valid also drops the response.
  - ic_flush has no effect on a dc-owned transaction.
- Latency:
  - Accept at cycle T → dram_req_valid at T+1.
  - DRAM response at R → resp pulse at R+1. The arbiter is also in IDLE at R+1, so the next accept is at R+1 at the earliest.
- dram_resp_valid arriving in IDLE or ISSUE is a protocol violation. It is ignored and there is no state change.
- resp_data outputs hold their last value when valid is 0. Only the valid pulse is meaningful.

Test Plan:
1. Single I$ refill: ic_req_valid=1, addr 0x0000_1040 at cycle 2; dram_req_ready=1 at cycle 4; dram_resp at cycle 8 with data 0xDEAD_BEEF_0000_0013 → ic_req_ready=1 at cycle 2; dram_req_valid=1 at cycles 3–4 with addr 0x1040, is_st=0; ic_resp_valid=1 at cycle 9 only, carrying that data; next dram_req_valid no earlier than cycle 10.
2. Round-robin: ic and dc both valid continuously, DRAM ready=1, 2-cycle response → grant order ic, dc, ic, dc; no back-to-back repeats; no dropped requests.
3. Flush during WAIT: I$ request outstanding, ic_flush=1 for one cycle before dram_resp_valid → ic_resp_valid stays 0; state returns to IDLE; a following ic request is accepted normally.
4. Flush coincident with the response cycle, and flush during a dc-owned transaction → the I$ response is dropped; the dc response is still delivered.
5. DRAM backpressure and store: dc store at addr 0x2000, wdata 0x55, dram_req_ready=0 for 5 cycles → dram_req_valid, addr and wdata are stable for all 5 cycles; the ack pulses dc_resp_valid with dc_resp_data=0.
6. Reset asserted in WAIT, then a stray dram_resp_valid after reset → all outputs 0; no resp pulse; ic wins the first subsequent tie.
